// File: rtl/spi_slave_regfile_if.sv
// Register-file side of an SPI slave: write/read pointer controls, event inputs
// and the decoded configuration outputs.
interface spi_slave_regfile_if #(
  parameter int REG_SIZE = 8,
  parameter int ADDR_W   = 3
);
  logic                  wr_addr_valid;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  wr_data_valid;
  logic [REG_SIZE-1:0]   wr_data;
  logic                  rd_addr_valid;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_next;
  logic [REG_SIZE-1:0]   rd_data;
  logic [REG_SIZE-1:0]   event_in;
  logic                  en_qpi;
  logic [7:0]            dummy_cycles;
  logic [2*REG_SIZE-1:0] wrap_length;
  logic                  cfg_update;
  logic                  irq;

  modport master (
    output wr_addr_valid, wr_addr, wr_data_valid, wr_data,
    output rd_addr_valid, rd_addr, rd_next, event_in,
    input  rd_data, en_qpi, dummy_cycles, wrap_length, cfg_update, irq
  );

  modport slave (
    input  wr_addr_valid, wr_addr, wr_data_valid, wr_data,
    input  rd_addr_valid, rd_addr, rd_next, event_in,
    output rd_data, en_qpi, dummy_cycles, wrap_length, cfg_update, irq
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave configuration register file: auto-incrementing write/read pointers,
// lockable config, double-buffered wrap length, W1C status with masked irq.
module spi_slave_regfile #(
  parameter int REG_SIZE      = 8,
  parameter int NUM_REGS      = 8,
  parameter int QUAD_EN       = 0,
  parameter int DUMMY_DEFAULT = 32,
  parameter int ID_VALUE      = 'hA5
) (
  input logic              sclk,
  input logic              rst,
  spi_slave_regfile_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DUMY = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_WRLO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_WRHI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(7);

  logic [REG_SIZE-1:0]   r_ctrl;
  logic [REG_SIZE-1:0]   r_dummy;
  logic [REG_SIZE-1:0]   r_shadow;
  logic [REG_SIZE-1:0]   r_wrap_hi;
  logic [REG_SIZE-1:0]   r_status;
  logic [REG_SIZE-1:0]   r_irq_mask;
  logic [REG_SIZE-1:0]   r_scr [NUM_REGS];
  logic [ADDR_W-1:0]     r_wptr;
  logic [ADDR_W-1:0]     r_rptr;
  logic [2*REG_SIZE-1:0] r_wrap_length;
  logic                  r_commit_pend;
  logic                  r_cfg_update;
  logic                  r_irq;

  logic [ADDR_W-1:0]     w_waddr;
  logic                  w_locked;
  logic                  w_commit;
  logic [REG_SIZE-1:0]   w_clr;
  logic [REG_SIZE-1:0]   w_rd_data;

  // A same-cycle address load redirects the data beat to the new address.
  assign w_waddr  = bus.wr_addr_valid ? bus.wr_addr : r_wptr;
  assign w_locked = r_ctrl[1];
  assign w_commit = bus.wr_data_valid && (w_waddr == A_WRHI) && !w_locked;
  assign w_clr    = (bus.wr_data_valid && (w_waddr == A_STAT)) ? bus.wr_data : '0;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_ctrl        <= (QUAD_EN != 0) ? REG_SIZE'(1) : '0;
      r_dummy       <= REG_SIZE'(DUMMY_DEFAULT);
      r_shadow      <= '0;
      r_wrap_hi     <= '0;
      r_status      <= '0;
      r_irq_mask    <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_scr[i] <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_wrap_length <= '0;
      r_commit_pend <= 1'b0;
      r_cfg_update  <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      // The commit samples reg3 one edge after it was written.
      r_cfg_update  <= r_commit_pend;
      if (r_commit_pend) r_wrap_length <= {r_wrap_hi, r_shadow};
      r_commit_pend <= w_commit;
      r_irq         <= |(r_status & r_irq_mask);
      r_status      <= (r_status & ~w_clr) | bus.event_in;

      if (bus.wr_data_valid) begin
        case (w_waddr)
          A_CTRL: r_ctrl <= bus.wr_data;
          A_DUMY: if (!w_locked) r_dummy <= bus.wr_data;
          A_WRLO: if (!w_locked) r_shadow <= bus.wr_data;
          A_WRHI: if (!w_locked) r_wrap_hi <= bus.wr_data;
          A_STAT: ;
          A_MASK: r_irq_mask <= bus.wr_data;
          A_ID:   ;
          default: r_scr[w_waddr] <= bus.wr_data;
        endcase
        r_wptr <= w_waddr + ADDR_W'(1);
      end else if (bus.wr_addr_valid) begin
        r_wptr <= bus.wr_addr;
      end

      if (bus.rd_addr_valid) r_rptr <= bus.rd_addr;
      else if (bus.rd_next)  r_rptr <= r_rptr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_rd_data = r_scr[r_rptr];
    case (r_rptr)
      A_CTRL:  w_rd_data = r_ctrl;
      A_DUMY:  w_rd_data = r_dummy;
      A_WRLO:  w_rd_data = r_shadow;
      A_WRHI:  w_rd_data = r_wrap_hi;
      A_STAT:  w_rd_data = r_status;
      A_MASK:  w_rd_data = r_irq_mask;
      A_ID:    w_rd_data = REG_SIZE'(ID_VALUE);
      default: w_rd_data = r_scr[r_rptr];
    endcase
  end

  assign bus.rd_data      = w_rd_data;
  assign bus.en_qpi       = r_ctrl[0];
  assign bus.dummy_cycles = r_dummy[7:0];
  assign bus.wrap_length  = r_wrap_length;
  assign bus.cfg_update   = r_cfg_update;
  assign bus.irq          = r_irq;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_spi_slave_regfile;
  localparam int N = 8;

  logic sclk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_slave_regfile_if #(.REG_SIZE(8), .ADDR_W(3)) bus ();

  spi_slave_regfile #(
    .REG_SIZE(8), .NUM_REGS(N), .QUAD_EN(0), .DUMMY_DEFAULT(32), .ID_VALUE('hA5)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Reference state: register contents by address (index 2 is the shadow).
  logic [7:0]  m_reg [N];
  logic [15:0] m_wrap;
  bit          m_cfg, m_pend, m_irq;
  int          m_wp, m_rp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] exp_rd;
    exp_rd = (m_rp == 7) ? 8'hA5 : m_reg[m_rp];
    chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    chk("wrap_length", 32'(bus.wrap_length), 32'(m_wrap));
    chk("cfg_update", 32'(bus.cfg_update), 32'(m_cfg));
    chk("irq", 32'(bus.irq), 32'(m_irq));
    chk("en_qpi", 32'(bus.en_qpi), 32'(m_reg[0][0]));
    chk("dummy_cycles", 32'(bus.dummy_cycles), 32'(m_reg[1]));
  endtask

  task automatic step(input bit rs, input bit wav, input logic [2:0] wa,
                      input bit wdv, input logic [7:0] wd, input bit rav,
                      input logic [2:0] ra, input bit rn, input logic [7:0] ev);
    logic [7:0]  nreg [N];
    logic [15:0] nwrap;
    bit          ncfg, npend, nirq;
    int          nwp, nrp, addr;
    logic [7:0]  clr;
    rst                   = rs;
    bus.wr_addr_valid     = wav;
    bus.wr_addr           = wa;
    bus.wr_data_valid     = wdv;
    bus.wr_data           = wd;
    bus.rd_addr_valid     = rav;
    bus.rd_addr           = ra;
    bus.rd_next           = rn;
    bus.event_in          = ev;
    nreg = m_reg;
    if (rs) begin
      foreach (nreg[i]) nreg[i] = 8'h00;
      nreg[1] = 8'd32;
      nwrap = 16'h0; ncfg = 0; npend = 0; nirq = 0; nwp = 0; nrp = 0;
    end else begin
      ncfg  = m_pend;
      nwrap = m_pend ? {m_reg[3], m_reg[2]} : m_wrap;
      npend = 0;
      nirq  = |(m_reg[4] & m_reg[5]);
      clr   = 8'h00;
      addr  = wav ? int'(wa) : m_wp;
      nwp   = wav ? int'(wa) : m_wp;
      if (wdv) begin
        if (addr == 0 || addr == 5 || addr == 6) nreg[addr] = wd;
        else if ((addr >= 1 && addr <= 3) && !m_reg[0][1]) begin
          nreg[addr] = wd;
          if (addr == 3) npend = 1;
        end else if (addr == 4) clr = wd;
        nwp = (addr + 1) % N;
      end
      nreg[4] = (m_reg[4] & ~clr) | ev;
      if (rav) nrp = int'(ra);
      else if (rn) nrp = (m_rp + 1) % N;
      else nrp = m_rp;
    end
    @(posedge sclk);
    #1;
    m_reg = nreg; m_wrap = nwrap; m_cfg = ncfg; m_pend = npend;
    m_irq = nirq; m_wp = nwp; m_rp = nrp;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 8'h00);
  endtask

  task automatic wr(input bit wav, input logic [2:0] wa, input logic [7:0] wd, input logic [7:0] ev);
    step(0, wav, wa, 1, wd, 0, 3'd0, 0, ev);
  endtask

  task automatic rd(input logic [2:0] ra);
    step(0, 0, 3'd0, 0, 8'h00, 1, ra, 0, 8'h00);
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = 8'h00;
    m_wrap = 0; m_cfg = 0; m_pend = 0; m_irq = 0; m_wp = 0; m_rp = 0;

    // Reset state and ID register
    step(1, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    chk("rst_en_qpi", 32'(bus.en_qpi), 32'h0);
    chk("rst_dummy", 32'(bus.dummy_cycles), 32'd32);
    chk("rst_wrap", 32'(bus.wrap_length), 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    rd(3'd7);
    chk("id_read", 32'(bus.rd_data), 32'hA5);

    // Lock blocks reg1 writes until ctrl is cleared
    wr(1, 3'd0, 8'h02, 8'h00);
    wr(0, 3'd0, 8'h08, 8'h00);
    chk("lock_dummy", 32'(bus.dummy_cycles), 32'd32);
    wr(1, 3'd0, 8'h00, 8'h00);
    wr(0, 3'd0, 8'h08, 8'h00);
    chk("unlock_dummy", 32'(bus.dummy_cycles), 32'd8);

    // Burst write into the wrap-length pair, then continue into status/mask
    wr(1, 3'd2, 8'h34, 8'h00);
    wr(0, 3'd0, 8'h12, 8'h00);
    chk("wrap_not_yet", 32'(bus.wrap_length), 32'h0);
    idle();
    chk("wrap_commit", 32'(bus.wrap_length), 32'h1234);
    chk("cfg_pulse", 32'(bus.cfg_update), 32'h1);
    idle();
    chk("cfg_drop", 32'(bus.cfg_update), 32'h0);
    wr(0, 3'd0, 8'h00, 8'h00);
    wr(0, 3'd0, 8'h01, 8'h00);
    rd(3'd5);
    chk("ptr_after_burst", 32'(bus.rd_data), 32'h01);

    // Pointer wrap 7 -> 0 -> 1; ctrl value keeps lock clear so reg1 accepts
    wr(1, 3'd7, 8'h11, 8'h00);
    wr(0, 3'd0, 8'h20, 8'h00);
    wr(0, 3'd0, 8'h33, 8'h00);
    rd(3'd7);
    chk("wrap_id", 32'(bus.rd_data), 32'hA5);
    rd(3'd0);
    chk("wrap_ctrl", 32'(bus.rd_data), 32'h20);
    step(0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 1, 8'h00);
    chk("wrap_reg1", 32'(bus.rd_data), 32'h33);
    wr(1, 3'd0, 8'h00, 8'h00);

    // Status / irq: mask is 'h01 from the burst above
    step(0, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 8'h01);
    chk("irq_lag", 32'(bus.irq), 32'h0);
    idle();
    chk("irq_set", 32'(bus.irq), 32'h1);
    wr(1, 3'd4, 8'h01, 8'h01);
    rd(3'd4);
    chk("set_wins", 32'(bus.rd_data), 32'h01);
    wr(1, 3'd4, 8'h01, 8'h00);
    chk("irq_hold", 32'(bus.irq), 32'h1);
    idle();
    chk("irq_clear", 32'(bus.irq), 32'h0);

    // Reset right after a reg3 write discards the commit
    wr(1, 3'd3, 8'hAB, 8'h00);
    step(1, 0, 3'd0, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    chk("rst_commit_wrap", 32'(bus.wrap_length), 32'h0);
    chk("rst_commit_cfg", 32'(bus.cfg_update), 32'h0);
    idle();
    chk("rst_commit_cfg2", 32'(bus.cfg_update), 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      bit         rs, wav, wdv, rav, rn;
      logic [7:0] wd, ev;
      rs  = ($urandom_range(0, 79) == 0);
      wav = ($urandom_range(0, 3) == 0);
      wdv = ($urandom_range(0, 1) == 0);
      rav = ($urandom_range(0, 3) == 0);
      rn  = ($urandom_range(0, 1) == 0);
      wd  = 8'($urandom);
      ev  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(rs, wav, 3'($urandom), wdv, wd, rav, 3'($urandom), rn, ev);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
